fa_response_checker: RTL
========================

FA_RESPONSE_CHECKER -- requirements
Module: fa_response_checker

Parameters
REQ-001 The block SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-002 The block SHALL have parameter VEC_W, default 8, giving the width of the vector counter.

Interface
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that arms a check run.
REQ-006 in_valid  input  1  qualifies a, b, c, sum and carry on the current cycle.
REQ-007 a, b, c  input  1 each  operand and carry-in bits applied to the full adder under test.
REQ-008 sum, carry  input  1 each  outputs returned by the full adder under test.
REQ-009 busy  output  1  high while in CHECK.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  high in DONE when err_count==0.
REQ-012 err_flag  output  1  sticky; set on the first mismatch of a run.
REQ-013 err_count  output  ERR_W  number of mismatches, saturating.
REQ-014 vec_count  output  VEC_W  number of accepted vectors, saturating.
REQ-015 coverage  output  8  bit index {a,b,c} set once that input combination has been checked.
REQ-016 first_err_vec  output  3  {a,b,c} of the first mismatching vector; 3'b000 if none.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, CHECK and DONE.
REQ-018 IDLE, start=1: go to CHECK on the next edge, and clear err_count, vec_count, coverage, err_flag and first_err_vec.
REQ-019 DONE, start=1: same clear and transition to CHECK as REQ-018.
REQ-020 CHECK, start=1: ignored, with no clear and no state change.
REQ-021 A vector SHALL be accepted only in CHECK with in_valid=1; in_valid in IDLE or DONE is ignored.
REQ-022 Expected values per accepted vector: exp_sum = a^b^c; exp_carry = (a&b)|(a&c)|(b&c).
REQ-023 Mismatch = (sum!=exp_sum) or (carry!=exp_carry).
REQ-024 On each accepted vector, vec_count SHALL increment by 1, holding at 2^VEC_W-1 once reached.
REQ-025 On each accepted vector, coverage[{a,b,c}] SHALL be set to 1; a bit is never cleared within a run.
REQ-026 On a mismatch, err_count SHALL increment by 1, holding at 2^ERR_W-1 once reached.
REQ-027 On the first mismatch of a run, err_flag SHALL be set and first_err_vec SHALL capture {a,b,c}.
REQ-028 Later mismatches in the same run SHALL leave first_err_vec unchanged.
REQ-029 Latency: every counter, flag and coverage update SHALL be visible exactly one cycle after the accepting edge.
REQ-030 CHECK to DONE: when the accepted vector completes coverage (coverage becomes 8'hFF), the FSM SHALL enter DONE on that same edge.
REQ-031 Therefore done SHALL rise in the same cycle the final coverage bit becomes visible.
REQ-032 Repeated vectors SHALL be counted and checked but SHALL NOT advance the run toward DONE.
REQ-033 In DONE, all outputs SHALL hold until start or rst.
REQ-034 pass SHALL be 0 in every state except DONE.
REQ-035 busy and done SHALL never be high together.
REQ-036 Inputs SHALL be sampled directly with no internal synchronizer; the caller provides inputs synchronous to clk.

Reset
REQ-037 While rst=1, on the edge: state = IDLE, and busy, done, pass, err_flag, err_count, vec_count, coverage and first_err_vec are all 0.
REQ-038 rst SHALL take priority over start and in_valid.
REQ-039 rst asserted mid-CHECK SHALL discard the run entirely; a new start is then required.

Verification
REQ-040 The bench SHALL cover these directed scenarios:
- Reset then start; apply the 8 vectors 000..111 with correct sum/carry, one per cycle -> done=1 one cycle after vector 111, pass=1, err_count=0, vec_count=8, coverage=8'hFF.
- Same run, but vector 011 returns sum=1, carry=1 -> err_flag=1, first_err_vec=3'b011, err_count=1, done=1, pass=0.
- Vectors 000, 000, 001 with in_valid gaps, then the remaining 6 vectors -> vec_count=9, done only after the 8th distinct vector, busy=1 throughout until then.
- Start pulsed during CHECK after 3 vectors -> no clear, vec_count continues from 3.
- rst asserted after 5 vectors -> all outputs 0 and state IDLE next cycle; subsequent in_valid ignored until start.
- ERR_W=2 with every vector wrong, 8 vectors -> err_count saturates at 3, first_err_vec=3'b000, pass=0.

Source files
------------

// File: rtl/fa_response_checker.sv
// rtl/fa_response_checker.sv - checks full-adder responses, counts vectors/errors and tracks input coverage
module fa_response_checker #(
  parameter int ERR_W = 8,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] vec_count,
  output logic [7:0]       coverage,
  output logic [2:0]       first_err_vec
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [VEC_W-1:0]   vec_count_q, vec_count_d;
  logic [7:0]         coverage_q, coverage_d;
  logic               err_flag_q, err_flag_d;
  logic [2:0]         first_err_vec_q, first_err_vec_d;

  logic [2:0] vec_idx;
  logic       accept;
  logic       clear;
  logic       exp_sum;
  logic       exp_carry;
  logic       mismatch;
  logic [7:0] cov_next;

  // Decode the incoming vector: golden full-adder result and the coverage it would produce
  always_comb begin
    vec_idx   = {a, b, c};
    accept    = (state_q == S_CHECK) && in_valid;
    // start re-arms only from IDLE or DONE; a start mid-run is ignored
    clear     = start && (state_q != S_CHECK);
    exp_sum   = a ^ b ^ c;
    exp_carry = (a & b) | (a & c) | (b & c);
    mismatch  = (sum != exp_sum) || (carry != exp_carry);
    cov_next  = coverage_q | (8'b1 << vec_idx);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      err_count_q     <= '0;
      vec_count_q     <= '0;
      coverage_q      <= '0;
      err_flag_q      <= 1'b0;
      first_err_vec_q <= 3'b000;
    end else begin
      state_q         <= state_d;
      err_count_q     <= err_count_d;
      vec_count_q     <= vec_count_d;
      coverage_q      <= coverage_d;
      err_flag_q      <= err_flag_d;
      first_err_vec_q <= first_err_vec_d;
    end
  end

  // Next state: the run ends on the edge that accepts the last uncovered combination
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: if (accept && (cov_next == 8'hFF)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_CHECK;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, coverage and first-error capture; counters saturate at all-ones
  always_comb begin
    err_count_d     = err_count_q;
    vec_count_d     = vec_count_q;
    coverage_d      = coverage_q;
    err_flag_d      = err_flag_q;
    first_err_vec_d = first_err_vec_q;
    if (clear) begin
      err_count_d     = '0;
      vec_count_d     = '0;
      coverage_d      = '0;
      err_flag_d      = 1'b0;
      first_err_vec_d = 3'b000;
    end else if (accept) begin
      coverage_d = cov_next;
      if (!(&vec_count_q)) vec_count_d = vec_count_q + VEC_W'(1);
      if (mismatch) begin
        if (!(&err_count_q)) err_count_d = err_count_q + ERR_W'(1);
        if (!err_flag_q) begin
          err_flag_d      = 1'b1;
          first_err_vec_d = vec_idx;
        end
      end
    end
  end

  // Outputs decoded from the state and the registered datapath
  always_comb begin
    busy          = (state_q == S_CHECK);
    done          = (state_q == S_DONE);
    pass          = (state_q == S_DONE) && (err_count_q == '0);
    err_flag      = err_flag_q;
    err_count     = err_count_q;
    vec_count     = vec_count_q;
    coverage      = coverage_q;
    first_err_vec = first_err_vec_q;
  end

endmodule
